// File: rtl/swipt_rx_decoder.sv
// SWIPT downlink receiver: slices ADC current into a line bit, recovers bit timing
// from the first rising edge and decodes one 23-bit frame (preamble, mode, type, data, parity, stop).
// The spec's `program` and `type` ports are SV keywords, so they appear here as prog and ftype.
module swipt_rx_decoder #(
  parameter int          BIT_PERIOD = 200000,
  parameter logic [11:0] MARGIN     = 12'd0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        swiptAlive,
  input  logic [1:0]  prog,
  input  logic        readDataIn,
  input  logic [11:0] ADC,
  input  logic [11:0] mean_def,
  output logic        din,
  output logic [1:0]  mode,
  output logic [1:0]  ftype,
  output logic        dataInReady,
  output logic [7:0]  dataIn,
  output logic [7:0]  sumChecker,
  output logic        checkSumBit
);

  localparam int PW = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 2;

  typedef enum logic [1:0] {IDLE, HUNT, SAMPLE, CHECK} state_t;

  state_t        state;
  logic          din_q;
  logic [PW-1:0] phase;
  logic [4:0]    bit_idx;
  logic [22:0]   shreg;
  logic [3:0]    pop;
  logic          keep, run, slice;

  assign keep  = swiptAlive & (prog == 2'b11);
  assign run   = keep & readDataIn;
  // 13-bit compare so mean_def + MARGIN cannot wrap
  assign slice = ({1'b0, ADC} > ({1'b0, mean_def} + {1'b0, MARGIN}));

  // shreg[12:5] holds the payload once all 23 bits are in
  always_comb begin
    pop = '0;
    for (int i = 0; i < 8; i++) pop = pop + {3'b0, shreg[5+i]};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      din         <= 1'b0;
      din_q       <= 1'b0;
      phase       <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      mode        <= '0;
      ftype       <= '0;
      dataIn      <= '0;
      sumChecker  <= '0;
      checkSumBit <= 1'b0;
      dataInReady <= 1'b0;
    end else begin
      din         <= run & slice;
      din_q       <= din;
      dataInReady <= 1'b0;
      if (!run) begin
        state <= IDLE;
        if (!keep) begin
          mode        <= '0;
          ftype       <= '0;
          dataIn      <= '0;
          sumChecker  <= '0;
          checkSumBit <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: state <= HUNT;
          HUNT: begin
            if (din && !din_q) begin
              phase   <= PW'(BIT_PERIOD/2 - 1);
              bit_idx <= '0;
              state   <= SAMPLE;
            end
          end
          SAMPLE: begin
            if (phase == '0) begin
              shreg   <= {shreg[21:0], din};
              phase   <= PW'(BIT_PERIOD - 1);
              bit_idx <= bit_idx + 5'd1;
              if (bit_idx == 5'd5 && {shreg[4:0], din} != 6'b101010) state <= HUNT;
              else if (bit_idx == 5'd22)                              state <= CHECK;
            end else begin
              phase <= phase - 1'b1;
            end
          end
          CHECK: begin
            // parity is reported as received; the consumer decides what to do with it
            if (shreg[3:0] == 4'b0101) begin
              mode        <= shreg[16:15];
              ftype       <= shreg[14:13];
              dataIn      <= shreg[12:5];
              checkSumBit <= shreg[4];
              sumChecker  <= {4'b0, pop};
              dataInReady <= 1'b1;
            end
            state <= HUNT;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_swipt_rx_decoder.sv
// Scoreboarded bench for swipt_rx_decoder: frames push expected decodes, a monitor pops on dataInReady.
module tb_swipt_rx_decoder;
  localparam int BP = 8;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        swiptAlive = 1'b1;
  logic [1:0]  prog = 2'b11;
  logic        readDataIn = 1'b0;
  logic [11:0] ADC = 12'd100;
  logic [11:0] mean_def = 12'd2048;
  logic        din, dataInReady, checkSumBit;
  logic [1:0]  mode, ftype;
  logic [7:0]  dataIn, sumChecker;

  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] typ;
    logic [7:0] data;
    logic [7:0] sum;
    logic       par;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  swipt_rx_decoder #(.BIT_PERIOD(BP), .MARGIN(12'd0)) dut (
    .clk(clk), .nrst(nrst), .swiptAlive(swiptAlive), .prog(prog),
    .readDataIn(readDataIn), .ADC(ADC), .mean_def(mean_def),
    .din(din), .mode(mode), .ftype(ftype), .dataInReady(dataInReady),
    .dataIn(dataIn), .sumChecker(sumChecker), .checkSumBit(checkSumBit)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // bits are sent MSB first from f[22]; abort_at drops readDataIn at that bit index
  task automatic send(input logic [22:0] f, input int nbits, input int abort_at);
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) readDataIn = 1'b0;
      ADC = f[22-i] ? 12'd4000 : 12'd100;
      step(BP);
    end
    ADC = 12'd100;
    step(3*BP);
  endtask

  function automatic exp_t mk(input logic [1:0] m, input logic [1:0] t, input logic [7:0] d,
                              input logic [7:0] s, input logic p);
    mk = '{mode: m, typ: t, data: d, sum: s, par: p};
  endfunction

  task automatic chk_out(input string name, input exp_t e);
    chk({name, ".mode"}, 32'(mode), 32'(e.mode));
    chk({name, ".type"}, 32'(ftype), 32'(e.typ));
    chk({name, ".data"}, 32'(dataIn), 32'(e.data));
    chk({name, ".sum"}, 32'(sumChecker), 32'(e.sum));
    chk({name, ".par"}, 32'(checkSumBit), 32'(e.par));
  endtask

  // monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (nrst && dataInReady) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk_out("frame", e);
      end
    end
  end

  initial begin
    exp_t f4;
    f4 = mk(2'd0, 2'd3, 8'h0F, 8'd4, 1'b0);

    #2;
    chk("reset_outputs", {19'b0, din, mode, ftype, dataInReady, dataIn, sumChecker, checkSumBit},
        32'd0);
    step(2);
    nrst = 1'b1;
    step(1);

    // slicer
    readDataIn = 1'b1;
    ADC = 12'd2049; step(1); chk("slice_2049", 32'(din), 32'd1);
    ADC = 12'd2048; step(1); chk("slice_2048", 32'(din), 32'd0);
    ADC = 12'd4095; readDataIn = 1'b0; step(1); chk("slice_disabled", 32'(din), 32'd0);
    ADC = 12'd100; step(2);
    readDataIn = 1'b1; step(3*BP);

    exp_q.push_back(mk(2'd2, 2'd1, 8'hB3, 8'd5, 1'b1));
    send(23'b101010_10_01_10110011_1_0101, 23, -1);
    chk_out("good_frame_hold", mk(2'd2, 2'd1, 8'hB3, 8'd5, 1'b1));

    exp_q.push_back(mk(2'd2, 2'd1, 8'hB3, 8'd5, 1'b0));
    send(23'b101010_10_01_10110011_0_0101, 23, -1);

    send({6'b101110, 17'b0}, 6, -1);
    exp_q.push_back(f4);
    send(23'b101010_00_11_00001111_0_0101, 23, -1);

    send(23'b101010_01_10_01010101_0_0110, 23, -1);
    chk_out("bad_stop_hold", f4);

    send(23'b101010_11_00_11110000_0_0101, 23, 14);
    chk_out("abort_hold", f4);
    readDataIn = 1'b1;
    step(2*BP);

    prog = 2'b01; step(1);
    chk_out("prog_clear", mk(2'd0, 2'd0, 8'h00, 8'd0, 1'b0));
    prog = 2'b11; step(3*BP);

    exp_q.push_back(mk(2'd1, 2'd2, 8'hA5, 8'd4, 1'b0));
    send(23'b101010_01_10_10100101_0_0101, 23, -1);
    chk_out("pre_reset", mk(2'd1, 2'd2, 8'hA5, 8'd4, 1'b0));

    ADC = 12'd4000; step(2);
    chk("din_before_reset", 32'(din), 32'd1);
    #3 nrst = 1'b0;
    #1;
    chk("async_reset", {19'b0, din, mode, ftype, dataInReady, dataIn, sumChecker, checkSumBit},
        32'd0);
    step(2);
    nrst = 1'b1;
    step(4);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/swipt_rx_decoder.md
Name: swipt_rx_decoder

Overview:
Receive path of the SWIPT data link. Slices the 12-bit ADC current samples against the mean current into a binary line signal `din`, recovers bit timing and decodes one downlink frame. The frame fields are mode, type, 8-bit data, parity bit and the preamble/stop patterns. The block sits beside the Data write/read controller, which enables it with `readDataIn` and consumes `dataInReady`, `mode`, `type` and `dataIn`.

Parameters:
BIT_PERIOD, 200000, clock cycles per received bit (2 ms at 100 MHz); must be ≥4; benches use 8.
MARGIN, 12'd0, hysteresis added to `mean_def` before comparison.

Ports:
clk  in  1  system clock
nrst  in  1  reset, asynchronous, active-low
swiptAlive  in  1  link alive; low forces idle
program  in  2  block runs only when 2'b11
readDataIn  in  1  receive enable from controller
ADC  in  12  current sample, unsigned
mean_def  in  12  mean current reference, unsigned
din  out  1  sliced line bit
mode  out  2  decoded mode field
type  out  2  decoded type field
dataInReady  out  1  one-cycle pulse: valid frame decoded
dataIn  out  8  decoded payload
sumChecker  out  8  popcount of decoded payload (zero-extended)
checkSumBit  out  1  received parity bit

Behaviour:
- Reset (`nrst` = 0, asynchronous) clears everything: all outputs 0, FSM in IDLE, counters 0.
- Enable: `run` = `swiptAlive` & (`program` == 2'b11) & `readDataIn`.
- When `run` = 0:
  - synchronously return to IDLE and clear `din` and `dataInReady`.
  - `mode`, `type`, `dataIn`, `sumChecker` and `checkSumBit` hold their last values.
  - Exception: `swiptAlive` = 0 or `program` != 2'b11 also clear these to 0.
- Slicer: `din` is registered, one-cycle latency. `din` <= `run` & ({1'b0,`ADC`} > {1'b0,`mean_def`} + `MARGIN`). Use 13-bit compare so the sum cannot wrap.
- Frame: 23 bits, MSB first.
  - preamble 6'b101010
  - mode[1:0]
  - type[1:0]
  - data[7:0]
  - parity bit (= ^data)
  - stop 4'b0101
- FSM states:
  - IDLE → HUNT when `run` = 1.
  - HUNT: wait for `din` 0→1 transition (registered previous value). On the edge, load the phase counter with BIT_PERIOD/2 − 1 → SAMPLE.
  - SAMPLE:
    - Phase counter decrements each clock. At 0, sample `din` into the shift register, increment the bit index (0..22) and reload BIT_PERIOD − 1.
    - After bit index 5, compare the shift register with 6'b101010. On mismatch → HUNT, without waiting for `din` to fall first.
    - After bit 22, check stop 4'b0101 → CHECK.
  - CHECK, one cycle:
    - If stop matches: latch `mode`, `type`, `dataIn`, `checkSumBit` (received bit), `sumChecker` = popcount(data), and pulse `dataInReady` = 1 for exactly one clock.
    - If stop mismatches: no pulse, outputs unchanged.
    - Either way → HUNT.
- Parity is reported, not enforced. `dataInReady` fires even if `checkSumBit` != ^`dataIn`; the consumer checks parity.
- `readDataIn` dropping mid-frame aborts the frame: no pulse, outputs hold.
- `din` edges during SAMPLE are ignored. Timing is free-running from the first edge, with no resynchronisation.
- All state other than the asynchronous reset is synchronous to `clk` rising edge.

Test Plan:
- Common setup for all scenarios: BIT_PERIOD=8, `program`=2'b11, `swiptAlive`=1, `mean_def`=2048.
- Slicer: `readDataIn`=1; `ADC`=2049 → `din`=1 one clock later; `ADC`=2048 → `din`=0; `readDataIn`=0 with `ADC`=4095 → `din`=0.
- Good frame: drive `ADC` 4000/100 per bit for 101010_10_01_10110011_1_0101 → `dataInReady` pulses 1 clock, `mode`=2, `type`=1, `dataIn`=8'hB3, `sumChecker`=5, `checkSumBit`=1.
- Bad parity, same frame with parity bit 0 → `dataInReady` pulses, `checkSumBit`=0, `dataIn`=8'hB3.
- Bad preamble 101110… → no pulse, FSM back in HUNT after bit 5. A following good frame with `dataIn`=8'h0F, `mode`=0, `type`=3 decodes correctly and pulses.
- Bad stop 0110 → no pulse, outputs keep the previous frame's values.
- Abort and reset:
  - `readDataIn` low mid-payload → no pulse, outputs held.
  - `program`=2'b01 → `mode`, `type`, `dataIn`, `sumChecker`, `checkSumBit` cleared to 0 on the next clock.
  - `nrst` low between clock edges → all outputs 0 immediately.
